// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM arbiter: the game CPU owns the port except inside the vblank window, where
// single-byte hiscore accesses run. Optional macro: HS_ARB_PAUSE_WINDOW_EN (pause opens the window).
module hiscore_ram_arbiter #(
    parameter int AW        = 11,
    parameter int SETTLE    = 4,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 64
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          vblank,
    input  logic          pause,
    input  logic          hs_req,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_wdata,
    output logic          hs_ack,
    output logic [7:0]    hs_rdata,
    output logic          cpu_halt,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    output logic          hs_owner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WIN,
        S_SETTLE,
        S_ACCESS,
        S_ACK,
        S_NEXT,
        S_RELEASE
    } state_t;

    localparam int CMAX = (SETTLE > RD_LAT) ? SETTLE : RD_LAT;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int BW   = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] RDLAT_LD  = CW'(RD_LAT - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam bit            UNLIMITED = (MAX_BURST == 0);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_burst;
    logic          r_halt;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rdata;
    logic          r_vb_d;
    logic          r_win_open;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [BW-1:0] w_burst_nxt;
    logic          w_halt_nxt;
    logic          w_owner_nxt;
    logic          w_latch;
    logic          w_capture;
    logic          w_vb_rise;
    logic          w_win;
    logic          w_burst_ok;

    assign w_vb_rise = vblank & ~r_vb_d;

`ifdef HS_ARB_PAUSE_WINDOW_EN
    // Pause holds the window open by level and lifts the burst limit while it lasts.
    assign w_win      = r_win_open | pause;
    assign w_burst_ok = UNLIMITED || pause || (r_burst < BURST_MAX);
`else
    logic w_unused_pause;
    assign w_unused_pause = pause;
    assign w_win          = r_win_open;
    assign w_burst_ok     = UNLIMITED || (r_burst < BURST_MAX);
`endif

    // The window is an edge event: it is dropped when vblank falls, when it goes unused
    // (no request waiting) and once a release has consumed it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vb_d     <= 1'b0;
            r_win_open <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            r_vb_d <= vblank;
            if (w_vb_rise) begin
                r_win_open <= 1'b1;
            end else if (!vblank || r_state == S_IDLE || r_state == S_RELEASE) begin
                r_win_open <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_burst <= '0;
            r_halt  <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_burst <= w_burst_nxt;
            r_halt  <= w_halt_nxt;
            r_owner <= w_owner_nxt;
            if (w_latch) begin
                r_we    <= hs_we;
                r_addr  <= hs_addr;
                r_wdata <= hs_wdata;
            end
            if (w_capture) begin
                r_rdata <= ram_dout;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // value unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_burst_nxt = r_burst;
        w_halt_nxt  = r_halt;
        w_owner_nxt = r_owner;
        w_latch     = 1'b0;
        w_capture   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (hs_req) begin
                    w_state_nxt = S_WAIT_WIN;
                end
            end
            S_WAIT_WIN: begin
                if (hs_req && w_win) begin
                    w_halt_nxt  = 1'b1;
                    w_cnt_nxt   = SETTLE_LD;
                    w_state_nxt = S_SETTLE;
                end else if (!hs_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (!w_win) begin
                    w_halt_nxt  = 1'b0;
                    w_state_nxt = S_RELEASE;
                end else if (r_cnt == '0) begin
                    w_owner_nxt = 1'b1;
                    w_latch     = 1'b1;
                    w_cnt_nxt   = RDLAT_LD;
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_ACCESS: begin
                if (r_we) begin
                    w_state_nxt = S_ACK;
                end else if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_ACK: begin
                if (!UNLIMITED && r_burst != BURST_MAX) begin
                    w_burst_nxt = r_burst + BW'(1);
                end
                // Owner is handed back here so it always drops a cycle ahead of cpu_halt.
                w_owner_nxt = 1'b0;
                w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (hs_req && w_win && w_burst_ok) begin
                    w_owner_nxt = 1'b1;
                    w_latch     = 1'b1;
                    w_cnt_nxt   = RDLAT_LD;
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_halt_nxt  = 1'b0;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_burst_nxt = '0;
                w_state_nxt = hs_req ? S_WAIT_WIN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign hs_ack   = (r_state == S_ACK);
    assign hs_rdata = r_rdata;
    assign cpu_halt = r_halt;
    assign hs_owner = r_owner;

    // CPU writes are dropped while the hiscore engine owns the port.
    assign ram_addr = r_owner ? r_addr  : cpu_addr;
    assign ram_din  = r_owner ? r_wdata : cpu_wdata;
    assign ram_we   = r_owner ? (r_we && r_state == S_ACCESS) : cpu_we;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: a default instance and a MAX_BURST=2 instance share one stimulus.
module tb_hiscore_ram_arbiter;

    typedef struct packed {
        logic        we;
        logic [10:0] addr;
        logic [7:0]  wdata;
    } req_t;

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
    } pre_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        vblank, pause, hs_req, hs_we, cpu_we;
    logic [10:0] hs_addr, cpu_addr;
    logic [7:0]  hs_wdata, cpu_wdata;

    logic        hs_ack_a, cpu_halt_a, ram_we_a, hs_owner_a;
    logic [7:0]  hs_rdata_a, ram_din_a, ram_dout_a;
    logic [10:0] ram_addr_a;
    logic        hs_ack_b, cpu_halt_b, ram_we_b, hs_owner_b;
    logic [7:0]  hs_rdata_b, ram_din_b, ram_dout_b;
    logic [10:0] ram_addr_b;

    logic        sel_b = 1'b0;
    logic        w_ack, w_halt, w_owner;
    logic [7:0]  w_rdata;

    assign w_ack   = sel_b ? hs_ack_b   : hs_ack_a;
    assign w_halt  = sel_b ? cpu_halt_b : cpu_halt_a;
    assign w_owner = sel_b ? hs_owner_b : hs_owner_a;
    assign w_rdata = sel_b ? hs_rdata_b : hs_rdata_a;

    hiscore_ram_arbiter u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank), .pause(pause),
        .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
        .hs_ack(hs_ack_a), .hs_rdata(hs_rdata_a), .cpu_halt(cpu_halt_a),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_we(ram_we_a),
        .ram_dout(ram_dout_a), .hs_owner(hs_owner_a)
    );

    hiscore_ram_arbiter #(.MAX_BURST(2)) u_dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank), .pause(pause),
        .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
        .hs_ack(hs_ack_b), .hs_rdata(hs_rdata_b), .cpu_halt(cpu_halt_b),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_we(ram_we_b),
        .ram_dout(ram_dout_b), .hs_owner(hs_owner_b)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM model: one registered read stage, so data sampled two edges after the address is valid.
    logic [7:0]  mem [0:2047];
    logic        pre_we = 1'b0;
    logic [10:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk_sys) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_a <= mem[ram_addr_a];
        ram_dout_b <= mem[ram_addr_b];
    end

    int errors = 0;
    int checks = 0;
    int cyc, halt_rises, releases, win_idx, vb_phase;
    int acks_per_win [0:7];
    logic prev_halt, prev_ack, vb_auto;

    req_t       req_q[$];
    logic [7:0] exp_rd_q[$];
    req_t       exp_wr_q[$];
    pre_t       pre_q[$];
    int         ack_cycles[$];

    task automatic step();
        req_t e;
        @(posedge clk_sys);
        cyc++;
        @(negedge clk_sys);
        checks++;
        if ((w_ack && prev_ack) || (w_owner && !w_halt))
        begin
            errors++;
            $display("FAIL invariant @%0d: ack=%b prev_ack=%b owner=%b halt=%b", cyc, w_ack, prev_ack, w_owner, w_halt);
        end
        if (w_halt && !prev_halt) begin
            halt_rises++;
            if (win_idx < 7) win_idx++;
        end
        if (!w_halt && prev_halt) releases++;
        if (w_ack) acks_per_win[win_idx]++;
        if (!sel_b && ram_we_a && hs_owner_a) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write @%0d: addr=%h data=%h", cyc, ram_addr_a, ram_din_a);
            end else begin
                e = exp_wr_q.pop_front();
                if (ram_addr_a !== e.addr || ram_din_a !== e.wdata) begin
                    errors++;
                    $display("FAIL write_data @%0d: got %h/%h want %h/%h", cyc, ram_addr_a, ram_din_a, e.addr, e.wdata);
                end
            end
        end
        prev_halt = w_halt;
        prev_ack  = w_ack;
        if (vb_auto) begin
            vb_phase = (vb_phase + 1) % 60;
            vblank   = (vb_phase >= 30);
        end
    endtask

    task automatic do_reset();
        pre_t p;
        reset_n = 1'b0; vblank = 1'b0; pause = 1'b0; hs_req = 1'b0; hs_we = 1'b0;
        hs_addr = '0; hs_wdata = '0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
        vb_auto = 1'b0; vb_phase = 0;
        step();
        while (pre_q.size() > 0) begin
            p = pre_q.pop_front();
            pre_we = 1'b1; pre_addr = p.addr; pre_data = p.data;
            step();
        end
        pre_we = 1'b0;
        step();
        reset_n = 1'b1;
        cyc = 0; halt_rises = 0; releases = 0; win_idx = 0;
        prev_halt = 1'b0; prev_ack = 1'b0;
        for (int i = 0; i < 8; i++) acks_per_win[i] = 0;
        req_q.delete(); exp_rd_q.delete(); exp_wr_q.delete(); ack_cycles.delete();
    endtask

    task automatic run_reqs(input int budget);
        int used = 0;
        logic [7:0] exp_d;
        while (req_q.size() > 0 && used < budget) begin
            hs_req = 1'b1; hs_we = req_q[0].we; hs_addr = req_q[0].addr; hs_wdata = req_q[0].wdata;
            step();
            used++;
            if (w_ack) begin
                ack_cycles.push_back(cyc);
                if (!req_q[0].we) begin
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL read_data: ack with no expected value, rdata=%h", w_rdata);
                    end else begin
                        exp_d = exp_rd_q.pop_front();
                        if (w_rdata !== exp_d) begin
                            errors++;
                            $display("FAIL read_data @%0d: got %h want %h", cyc, w_rdata, exp_d);
                        end
                    end
                end
                void'(req_q.pop_front());
            end
        end
        hs_req = 1'b0;
        checks++;
        if (req_q.size() != 0) begin
            errors++;
            $display("FAIL req_timeout: %0d requests left, want 0", req_q.size());
            req_q.delete();
        end
        repeat (4) step();
    endtask

    task automatic wait_ack(input string name, input int budget);
        int n = 0;
        do begin step(); n++; end while (!w_ack && n < budget);
        checks++;
        if (!w_ack) begin errors++; $display("FAIL %s: ack=0 after %0d cycles, want 1", name, n); end
    endtask

    task automatic wait_owner(input string name, input int budget);
        int n = 0;
        do begin step(); n++; end while (!w_owner && n < budget);
        checks++;
        if (!w_owner) begin errors++; $display("FAIL %s: owner=0 after %0d cycles, want 1", name, n); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({hs_ack_a, hs_rdata_a, cpu_halt_a, hs_owner_a, hs_ack_b, cpu_halt_b, hs_owner_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b rdata=%h halt=%b owner=%b, want all 0", hs_ack_a, hs_rdata_a, cpu_halt_a, hs_owner_a);
        end
    endtask

    task automatic test_write_latency();
        do_reset();
        exp_wr_q.push_back('{we: 1'b1, addr: 11'h1A5, wdata: 8'h5C});
        hs_req = 1'b1; hs_we = 1'b1; hs_addr = 11'h1A5; hs_wdata = 8'h5C;
        while (cyc < 99) step();
        vblank = 1'b1;
        step();
        checks++; if (cpu_halt_a !== 1'b0) begin errors++; $display("FAIL halt_c100: got %b want 0", cpu_halt_a); end
        step();
        checks++; if (cpu_halt_a !== 1'b1) begin errors++; $display("FAIL halt_c101: got %b want 1", cpu_halt_a); end
        repeat (3) step();
        checks++; if (ram_we_a !== 1'b0) begin errors++; $display("FAIL we_c104: got %b want 0", ram_we_a); end
        step();
        checks++;
        if (ram_we_a !== 1'b1 || ram_addr_a !== 11'h1A5 || ram_din_a !== 8'h5C || hs_ack_a !== 1'b0) begin
            errors++;
            $display("FAIL write_c105: we=%b addr=%h din=%h ack=%b want 1/1a5/5c/0", ram_we_a, ram_addr_a, ram_din_a, hs_ack_a);
        end
        step();
        checks++; if (hs_ack_a !== 1'b1 || ram_we_a !== 1'b0) begin errors++; $display("FAIL ack_c106: ack=%b we=%b want 1/0", hs_ack_a, ram_we_a); end
        hs_req = 1'b0;
        step();
        checks++; if (hs_owner_a !== 1'b0 || cpu_halt_a !== 1'b1) begin errors++; $display("FAIL handback_c107: owner=%b halt=%b want 0/1", hs_owner_a, cpu_halt_a); end
        step();
        checks++; if (cpu_halt_a !== 1'b0) begin errors++; $display("FAIL halt_c108: got %b want 0", cpu_halt_a); end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_read_burst();
        pre_q.push_back('{addr: 11'h010, data: 8'hA1});
        pre_q.push_back('{addr: 11'h011, data: 8'hA2});
        pre_q.push_back('{addr: 11'h012, data: 8'hA3});
        do_reset();
        for (int i = 0; i < 3; i++) req_q.push_back('{we: 1'b0, addr: 11'(11'h010 + i), wdata: 8'h00});
        exp_rd_q.push_back(8'hA1); exp_rd_q.push_back(8'hA2); exp_rd_q.push_back(8'hA3);
        vb_auto = 1'b1;
        run_reqs(300);
        vb_auto = 1'b0; vblank = 1'b0;
        checks++;
        if (ack_cycles.size() != 3 || ack_cycles[1] - ack_cycles[0] != 4 || ack_cycles[2] - ack_cycles[1] != 4) begin
            errors++;
            $display("FAIL burst_spacing: %0d acks, want 3 acks 4 cycles apart", ack_cycles.size());
        end
        checks++;
        if (halt_rises != 1 || releases != 1) begin
            errors++;
            $display("FAIL burst_single_window: halts=%0d releases=%0d want 1/1", halt_rises, releases);
        end
    endtask

    task automatic test_max_burst();
        for (int i = 0; i < 5; i++) pre_q.push_back('{addr: 11'(11'h030 + i), data: 8'(8'hC0 + i)});
        do_reset();
        sel_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_q.push_back('{we: 1'b0, addr: 11'(11'h030 + i), wdata: 8'h00});
            exp_rd_q.push_back(8'(8'hC0 + i));
        end
        vb_auto = 1'b1;
        run_reqs(800);
        vb_auto = 1'b0; vblank = 1'b0;
        checks++;
        if (halt_rises != 3 || acks_per_win[1] != 2 || acks_per_win[2] != 2 || acks_per_win[3] != 1) begin
            errors++;
            $display("FAIL max_burst_split: windows=%0d acks=%0d/%0d/%0d want 3 windows 2/2/1",
                     halt_rises, acks_per_win[1], acks_per_win[2], acks_per_win[3]);
        end
        sel_b = 1'b0;
    endtask

    task automatic test_vblank_fall();
        int halted = 0;
        pre_q.push_back('{addr: 11'h040, data: 8'h77});
        pre_q.push_back('{addr: 11'h041, data: 8'h88});
        pre_q.push_back('{addr: 11'h020, data: 8'h11});
        do_reset();
        hs_req = 1'b1; hs_we = 1'b0; hs_addr = 11'h040;
        repeat (3) step();
        vblank = 1'b1;
        wait_owner("vbf_owner", 20);
        vblank = 1'b0;
        cpu_we = 1'b1; cpu_addr = 11'h020; cpu_wdata = 8'hEE;
        step();
        checks++; if (ram_we_a !== 1'b0 || hs_owner_a !== 1'b1) begin errors++; $display("FAIL cpu_write_dropped: we=%b owner=%b want 0/1", ram_we_a, hs_owner_a); end
        cpu_we = 1'b0;
        wait_ack("vbf_ack", 10);
        checks++; if (hs_rdata_a !== 8'h77) begin errors++; $display("FAIL vbf_rdata: got %h want 77", hs_rdata_a); end
        hs_addr = 11'h041;
        repeat (3) step();
        repeat (20) begin step(); if (cpu_halt_a) halted++; end
        checks++; if (halted != 0 || mem[11'h020] !== 8'h11) begin errors++; $display("FAIL no_grant_after_fall: halt_cycles=%0d mem20=%h want 0/11", halted, mem[11'h020]); end
        vblank = 1'b1;
        wait_ack("vbf_ack2", 30);
        checks++; if (hs_rdata_a !== 8'h88) begin errors++; $display("FAIL vbf_rdata2: got %h want 88", hs_rdata_a); end
        hs_req = 1'b0;
        repeat (5) step();
        hs_req = 1'b1; hs_addr = 11'h040;
        halted = 0;
        repeat (15) begin step(); if (cpu_halt_a) halted++; end
        checks++; if (halted != 0) begin errors++; $display("FAIL midblank_request: halt_cycles=%0d want 0", halted); end
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        wait_ack("midblank_ack", 30);
        checks++; if (hs_rdata_a !== 8'h77) begin errors++; $display("FAIL midblank_rdata: got %h want 77", hs_rdata_a); end
        hs_req = 1'b0; vblank = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_async_reset();
        pre_q.push_back('{addr: 11'h050, data: 8'h5A});
        pre_q.push_back('{addr: 11'h051, data: 8'h6B});
        do_reset();
        hs_req = 1'b1; hs_we = 1'b0; hs_addr = 11'h050;
        repeat (2) step();
        vblank = 1'b1;
        wait_ack("rst_first_ack", 20);
        checks++; if (hs_rdata_a !== 8'h5A) begin errors++; $display("FAIL rst_pre_rdata: got %h want 5a", hs_rdata_a); end
        hs_addr = 11'h051;
        wait_owner("rst_owner", 10);
        cpu_addr = 11'h155; cpu_wdata = 8'h3C; cpu_we = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({hs_ack_a, hs_rdata_a, cpu_halt_a, hs_owner_a} !== '0) begin
            errors++;
            $display("FAIL async_reset: ack=%b rdata=%h halt=%b owner=%b want all 0", hs_ack_a, hs_rdata_a, cpu_halt_a, hs_owner_a);
        end
        checks++;
        if (ram_addr_a !== 11'h155 || ram_din_a !== 8'h3C || ram_we_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_mux: addr=%h din=%h we=%b want 155/3c/1", ram_addr_a, ram_din_a, ram_we_a);
        end
        step();
        checks++; if (ram_addr_a !== 11'h155 || ram_we_a !== 1'b1) begin errors++; $display("FAIL reset_mux_next: addr=%h we=%b want 155/1", ram_addr_a, ram_we_a); end
        hs_req = 1'b0; cpu_we = 1'b0; vblank = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_pause();
`ifdef HS_ARB_PAUSE_WINDOW_EN
        do_reset();
        for (int i = 0; i < 100; i++) begin
            req_q.push_back('{we: 1'b1, addr: 11'(11'h100 + i), wdata: 8'(i ^ 8'h5A)});
            exp_wr_q.push_back('{we: 1'b1, addr: 11'(11'h100 + i), wdata: 8'(i ^ 8'h5A)});
        end
        step();
        pause = 1'b1;
        run_reqs(1000);
        pause = 1'b0;
        checks++;
        if (halt_rises != 1 || releases != 1 || acks_per_win[1] != 100 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL pause_window: halts=%0d releases=%0d acks=%0d left=%0d want 1/1/100/0",
                     halt_rises, releases, acks_per_win[1], exp_wr_q.size());
        end
`else
        int halted = 0;
        do_reset();
        pause = 1'b1;
        hs_req = 1'b1; hs_we = 1'b1; hs_addr = 11'h0AA; hs_wdata = 8'h99;
        repeat (40) begin step(); if (cpu_halt_a || hs_ack_a) halted++; end
        checks++; if (halted != 0) begin errors++; $display("FAIL pause_ignored: busy_cycles=%0d want 0", halted); end
        pause = 1'b0;
        req_q.push_back('{we: 1'b1, addr: 11'h0AA, wdata: 8'h99});
        exp_wr_q.push_back('{we: 1'b1, addr: 11'h0AA, wdata: 8'h99});
        vblank = 1'b1;
        run_reqs(30);
        vblank = 1'b0;
        checks++; if (exp_wr_q.size() != 0 || mem[11'h0AA] !== 8'h99) begin errors++; $display("FAIL vblank_grant: left=%0d mem=%h want 0/99", exp_wr_q.size(), mem[11'h0AA]); end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_latency();
        test_read_burst();
        test_max_burst();
        test_vblank_fall();
        test_async_reset();
        test_pause();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hiscore_ram_arbiter.md
Name: hiscore_ram_arbiter

Overview:
- Shares the game work-RAM port between the running game CPU and the hiscore save/restore engine.
- Hiscore accesses are granted only inside a safe window: the vertical blank.
- Before each window the arbiter halts the CPU and waits a settle period, then runs one or more single-byte accesses using a req/ack handshake.
- Sits between the hiscore engine and the core's RAM mux, in the clk_sys domain.

Parameters:
- AW, 11, RAM address width.
- SETTLE, 4, clk_sys cycles between raising cpu_halt and the first RAM access (CPU bus quiesce); must be ≥1.
- RD_LAT, 2, clk_sys cycles from driving a read address to hs_rdata being valid; must be ≥1.
- MAX_BURST, 64, maximum accesses granted per window; 0 means unlimited.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- vblank  in  1  vertical blank from video timing (level)
- pause  in  1  user pause (level)
- hs_req  in  1  hiscore access request; held until hs_ack
- hs_we  in  1  1 = write, 0 = read; sampled with hs_req
- hs_addr  in  AW  hiscore address
- hs_wdata  in  8  hiscore write data
- hs_ack  out  1  one-cycle pulse: access complete
- hs_rdata  out  8  read data; valid while hs_ack=1 and held until the next ack
- cpu_halt  out  1  halt request to the game CPU
- cpu_addr  in  AW  CPU RAM address
- cpu_wdata  in  8  CPU write data
- cpu_we  in  1  CPU write strobe
- ram_addr  out  AW  muxed RAM address
- ram_din  out  8  muxed RAM write data
- ram_we  out  1  muxed RAM write strobe
- ram_dout  in  8  RAM read data
- hs_owner  out  1  1 while hiscore owns the RAM port

Behaviour:
- Reset (async, reset_n=0) sets: state=IDLE, hs_ack=0, hs_rdata=0, cpu_halt=0, hs_owner=0, burst counter=0, window latch=0.
- Window:
  - win_open is a registered vblank rising edge, latched until vblank falls.
  - A request that arrives mid-vblank waits for the next rising edge; the window is never opened mid-blank.
- RAM mux:
  - hs_owner=0: ram_* = cpu_* combinationally.
  - hs_owner=1: ram_addr=hs_addr latched, ram_din=hs_wdata latched, ram_we driven by the FSM only; CPU writes are dropped.
- States:
  - IDLE: if hs_req, go to WAIT_WIN.
  - WAIT_WIN: if win_open, set cpu_halt=1, load settle counter=SETTLE-1, go to SETTLE. If hs_req drops, go to IDLE.
  - SETTLE: decrement the counter; at 0, set hs_owner=1, latch addr/we/wdata, go to ACCESS.
  - ACCESS:
    - Write: ram_we=1 for exactly 1 cycle, then ACK.
    - Read: hold the address for RD_LAT cycles, capture ram_dout into hs_rdata, then ACK.
  - ACK: hs_ack=1 for 1 cycle; burst counter +1; go to NEXT.
  - NEXT:
    - Continue (re-latch, go to ACCESS with no settle) if hs_req=1, the window is still open, and the burst counter < MAX_BURST.
    - Otherwise go to RELEASE.
  - RELEASE: hs_owner=0, cpu_halt=0, burst counter=0. Go to WAIT_WIN if hs_req, else IDLE.
- Boundary conditions:
  - An access in progress is never aborted. If vblank falls during SETTLE or ACCESS, the current access completes, then RELEASE.
  - If vblank falls during SETTLE with no access started, go straight to RELEASE.
  - hs_req deasserted mid-access is illegal; the arbiter completes the access anyway.
  - hs_ack is asserted only in ACK.
  - hs_ack and a new grant never coincide: there is at least one NEXT cycle between acks.
  - The burst counter saturates at MAX_BURST; after RELEASE it resets and waits for the next vblank edge.
  - The owner hand-back is registered: hs_owner=0 one cycle before cpu_halt=0 deasserts.
- Latency (write, window already pending): vblank edge → cpu_halt +1 cycle → first ram_we after SETTLE cycles → hs_ack +1.

Optional Feature:
- Macro: HS_ARB_PAUSE_WINDOW_EN.
- Defined:
  - pause=1 also opens the window (win_open = vblank_window | pause). The pause rising edge counts as a window edge.
  - While pause=1 and vblank falls, the window stays open.
  - MAX_BURST is ignored while pause=1.
- Not defined: the pause input is ignored; the window is vblank only.

Test Plan:
1. Reset, then hs_req write addr=11'h1A5, data=8'h5C before vblank; raise vblank at cycle 100 → cpu_halt=1 at cycle 101, ram_we=1 with ram_addr=11'h1A5 and ram_din=8'h5C at cycle 101+SETTLE=105, hs_ack pulse at 106, cpu_halt=0 at 108.
2. Read burst of 3 at addrs 0x010..0x012, RAM preloaded 8'hA1/8'hA2/8'hA3, RD_LAT=2 → one halt/settle, hs_rdata=A1,A2,A3 on successive acks 4 cycles apart, single release.
3. MAX_BURST=2 with 5 queued reads → 2 acks in window 1, release, remaining 3 served as 2 in window 2 and 1 in window 3; hs_owner=0 between windows.
4. vblank falls during ACCESS of a read → that read still acks with correct data; next request waits for the next vblank rising edge; CPU write to 0x020 during hs_owner=1 is not seen on ram_we.
5. reset_n=0 asserted mid-ACCESS → all outputs 0 immediately (async); ram_* follows cpu_* the next cycle.
6. With HS_ARB_PAUSE_WINDOW_EN, vblank held 0 and pause 0→1, 100 queued writes → all 100 acked, no release until the queue empties. Without the macro → no grant until vblank.
